// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: queued command, returned response,
// and the sequencer FSM states.
package i2c_pkg;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
  } i2c_cmd_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       nack;
    logic       timeout;
  } i2c_rsp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } seq_state_t;

  localparam i2c_rsp_t RSP_TIMEOUT = '{rdata: 8'h00, nack: 1'b0, timeout: 1'b1};

  // Read data is only meaningful for an acknowledged read; everything else returns zero.
  function automatic i2c_rsp_t done_rsp(input logic rw, input logic ack_error,
                                        input logic [7:0] data_out);
    i2c_rsp_t r;
    r.rdata   = (rw && !ack_error) ? data_out : 8'h00;
    r.nack    = ack_error;
    r.timeout = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO; the head entry is visible combinationally so a pop
// can load it into the master-facing registers on the same edge.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_400,
  input  logic                   rst_n,
  input  logic                   push,
  input  i2c_cmd_t               push_data,
  input  logic                   pop,
  output i2c_cmd_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  i2c_cmd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_400) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for the single-byte I2C master: queues commands, issues them
// one at a time over start_txn/busy/done and returns one response per command.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_400,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [6:0]             cmd_addr,
  input  logic [7:0]             cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_nack,
  output logic                   rsp_timeout,
  output logic                   m_start_txn,
  output logic                   m_rw,
  output logic [6:0]             m_sub_addr,
  output logic [7:0]             m_data_in,
  input  logic [7:0]             m_data_out,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic                   m_ack_error,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   idle
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  seq_state_t state;
  seq_state_t state_nxt;
  i2c_cmd_t   head;
  i2c_rsp_t   rsp_nxt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       start_clr;
  logic       rsp_load;
  logic       timed_out;
  logic [TW-1:0] timer;

  i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_400   (clk_400),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ('{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign cmd_ready = !fifo_full;
  assign idle      = (state == S_IDLE) && fifo_empty;
  assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_400) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A completed transaction wins over a timeout expiring in the same cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start_clr = 1'b0;
    rsp_load  = 1'b0;
    rsp_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !rsp_valid) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (timed_out) begin
          start_clr = 1'b1;
          rsp_load  = 1'b1;
          rsp_nxt   = RSP_TIMEOUT;
          state_nxt = S_GAP;
        end else if (m_busy) begin
          start_clr = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_done) begin
          rsp_load  = 1'b1;
          rsp_nxt   = done_rsp(m_rw, m_ack_error, m_data_out);
          state_nxt = S_GAP;
        end else if (timed_out) begin
          start_clr = 1'b1;
          rsp_load  = 1'b1;
          rsp_nxt   = RSP_TIMEOUT;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!m_busy && !m_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Master-facing fields only move on a pop, so they stay put for the whole transaction.
  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      m_start_txn <= 1'b0;
      m_rw        <= 1'b0;
      m_sub_addr  <= '0;
      m_data_in   <= '0;
      timer       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (pop) begin
        m_rw        <= head.rw;
        m_sub_addr  <= head.addr;
        m_data_in   <= head.wdata;
        m_start_txn <= 1'b1;
        timer       <= '0;
      end else begin
        if (start_clr) m_start_txn <= 1'b0;
        if (state == S_ISSUE || state == S_WAIT) timer <= timer + TW'(1);
      end
      if (rsp_load) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= rsp_nxt.rdata;
        rsp_nack    <= rsp_nxt.nack;
        rsp_timeout <= rsp_nxt.timeout;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: a behavioural master/target model answers each
// transaction, and a queue of accepted commands predicts every response in order.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TOUT  = 16;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       tout;
  } cmd_rec_t;

  logic       clk_400   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw    = 1'b0;
  logic [6:0] cmd_addr  = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_ready = 1'b0;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_timeout;
  logic       m_start_txn;
  logic       m_rw;
  logic [6:0] m_sub_addr;
  logic [7:0] m_data_in;
  logic [7:0] m_data_out;
  logic       m_busy;
  logic       m_done;
  logic       m_ack_error;
  logic [2:0] fifo_level;
  logic       idle;

  int       vectors     = 0;
  int       miscompares = 0;
  int       cyc         = 0;
  cmd_rec_t exp_q[$];
  cmd_rec_t iss_q[$];

  logic       stuck       = 1'b0;
  logic       release_bus = 1'b0;
  int         ph          = 0;
  int         cnt         = 0;
  logic       chk_drop    = 1'b0;
  logic       cap_rw;
  logic [6:0] cap_addr;
  logic [7:0] cap_wdata;
  cmd_rec_t   ie;

  logic       held = 1'b0;
  logic [9:0] last_rsp;
  logic [9:0] got_rsp;
  logic [9:0] want_rsp;
  cmd_rec_t   re;

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_400     (clk_400),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_nack    (rsp_nack),
    .rsp_timeout (rsp_timeout),
    .m_start_txn (m_start_txn),
    .m_rw        (m_rw),
    .m_sub_addr  (m_sub_addr),
    .m_data_in   (m_data_in),
    .m_data_out  (m_data_out),
    .m_busy      (m_busy),
    .m_done      (m_done),
    .m_ack_error (m_ack_error),
    .fifo_level  (fifo_level),
    .idle        (idle)
  );

  always #5 clk_400 = ~clk_400;

  initial forever begin
    @(posedge clk_400);
    cyc++;
  end

  // The bus target NACKs 0x11 and 0x70-0x77; read data is a fixed function of the address.
  function automatic logic target_nack(input logic [6:0] a);
    return (a == 7'h11) || (a[6:3] == 4'b1110);
  endfunction

  function automatic logic [7:0] target_rdata(input logic [6:0] a);
    if (a == 7'h50) return 8'h3C;
    return {a, 1'b1} ^ 8'hC3;
  endfunction

  function automatic logic [9:0] expRsp(input cmd_rec_t c);
    logic nk;
    if (c.tout) return {8'h00, 1'b0, 1'b1};
    nk = target_nack(c.addr);
    return {(c.rw && !nk) ? target_rdata(c.addr) : 8'h00, nk, 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_400);
    #1;
  endtask

  task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                               input logic tout, input bit rand_ready);
    logic was_ready;
    int   n;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    do begin
      was_ready = cmd_ready;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!was_ready && n < 300);
    cmd_valid = 1'b0;
    checkOutput("cmd_accepted", 32'(was_ready), 32'(1));
    if (was_ready) begin
      exp_q.push_back('{rw: rw, addr: addr, wdata: wdata, tout: tout});
      iss_q.push_back('{rw: rw, addr: addr, wdata: wdata, tout: tout});
    end
  endtask

  task automatic drain();
    int n;
    n         = 0;
    rsp_ready = 1'b1;
    while (!(exp_q.size() == 0 && idle && !rsp_valid) && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("drain_done", 32'(exp_q.size() == 0 && idle && !rsp_valid), 32'(1));
  endtask

  // Master model: busy two cycles after start is seen, then a done pulse with busy low.
  initial begin : master_bfm
    m_busy      = 1'b0;
    m_done      = 1'b0;
    m_ack_error = 1'b0;
    m_data_out  = '0;
    forever begin
      @(negedge clk_400);
      if (!rst_n) begin
        ph          = 0;
        m_busy      = 1'b0;
        m_done      = 1'b0;
        m_ack_error = 1'b0;
      end else begin
        case (ph)
          0: if (m_start_txn) begin
               cap_rw    = m_rw;
               cap_addr  = m_sub_addr;
               cap_wdata = m_data_in;
               checkOutput("issue_expected", 32'(iss_q.size() > 0), 32'(1));
               if (iss_q.size() > 0) begin
                 ie = iss_q.pop_front();
                 checkOutput("issue_rw", 32'(cap_rw), 32'(ie.rw));
                 checkOutput("issue_addr", 32'(cap_addr), 32'(ie.addr));
                 checkOutput("issue_wdata", 32'(cap_wdata), 32'(ie.wdata));
               end
               cnt = 1;
               ph  = 1;
             end
          1: if (cnt == 0) begin
               m_busy   = 1'b1;
               chk_drop = 1'b1;
               cnt      = $urandom_range(0, 5);
               ph       = 2;
             end else begin
               cnt--;
             end
          2: begin
               if (chk_drop) begin
                 checkOutput("start_drop", 32'(m_start_txn), 32'(0));
                 chk_drop = 1'b0;
               end
               if (stuck) begin
                 if (release_bus) begin
                   m_busy = 1'b0;
                   ph     = 0;
                 end
               end else if (cnt == 0) begin
                 checkOutput("hold_rw", 32'(m_rw), 32'(cap_rw));
                 checkOutput("hold_addr", 32'(m_sub_addr), 32'(cap_addr));
                 checkOutput("hold_wdata", 32'(m_data_in), 32'(cap_wdata));
                 m_busy      = 1'b0;
                 m_done      = 1'b1;
                 m_ack_error = target_nack(cap_addr);
                 m_data_out  = target_rdata(cap_addr);
                 ph          = 3;
               end else begin
                 cnt--;
               end
             end
          3: begin
               m_done      = 1'b0;
               m_ack_error = 1'b0;
               ph          = 0;
             end
          default: ph = 0;
        endcase
      end
    end
  end

  initial begin : rsp_monitor
    forever begin
      @(negedge clk_400);
      got_rsp = {rsp_rdata, rsp_nack, rsp_timeout};
      if (rst_n && rsp_valid) begin
        if (held) checkOutput("rsp_stable", 32'(got_rsp), 32'(last_rsp));
        if (rsp_ready) begin
          checkOutput("rsp_pending", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) begin
            re       = exp_q.pop_front();
            want_rsp = expRsp(re);
            checkOutput("rsp_rdata", 32'(got_rsp[9:2]), 32'(want_rsp[9:2]));
            checkOutput("rsp_nack", 32'(got_rsp[1]), 32'(want_rsp[1]));
            checkOutput("rsp_timeout", 32'(got_rsp[0]), 32'(want_rsp[0]));
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          last_rsp = got_rsp;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int         n;
    int         t0;
    logic       r6;
    logic [6:0] a6;
    logic [7:0] d6;

    repeat (3) tick();
    checkOutput("rst_level", 32'(fifo_level), 32'(0));
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    checkOutput("rst_rsp_nack", 32'(rsp_nack), 32'(0));
    checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'(0));
    checkOutput("rst_start", 32'(m_start_txn), 32'(0));
    checkOutput("rst_m_rw", 32'(m_rw), 32'(0));
    checkOutput("rst_m_addr", 32'(m_sub_addr), 32'(0));
    checkOutput("rst_m_data", 32'(m_data_in), 32'(0));
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    checkOutput("rst_idle", 32'(idle), 32'(1));
    rst_n = 1'b1;
    tick();

    $display("[TB] directed write, read and nack");
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 7'h2A, 8'hA5, 1'b0, 1'b0);
    checkOutput("issue_latency_pre", 32'(m_start_txn), 32'(0));
    tick();
    checkOutput("issue_latency", 32'(m_start_txn), 32'(1));
    checkOutput("pop_level", 32'(fifo_level), 32'(0));
    drain();
    applyStimulus(1'b1, 7'h50, 8'h5F, 1'b0, 1'b0);
    drain();
    applyStimulus(1'b0, 7'h11, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'h50, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    checkOutput("nack_rsp_seen", 32'(rsp_valid), 32'(1));
    checkOutput("nack_flag", 32'(rsp_nack), 32'(1));
    n = 0;
    while (!m_start_txn && n < 50) begin tick(); n++; end
    checkOutput("next_start_gap", 32'(n), 32'(2));
    drain();

    $display("[TB] fifo fill with response held");
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, 1'b0);
    checkOutput("full_level", 32'(fifo_level), 32'(DEPTH));
    checkOutput("full_ready", 32'(cmd_ready), 32'(0));
    r6 = 1'($urandom);
    a6 = 7'($urandom);
    d6 = 8'($urandom);
    cmd_valid = 1'b1;
    cmd_rw    = r6;
    cmd_addr  = a6;
    cmd_wdata = d6;
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    checkOutput("held_rsp_valid", 32'(rsp_valid), 32'(1));
    repeat (4) tick();
    checkOutput("held_level", 32'(fifo_level), 32'(DEPTH));
    checkOutput("refuse_ready", 32'(cmd_ready), 32'(0));
    checkOutput("held_no_issue", 32'(m_start_txn), 32'(0));
    rsp_ready = 1'b1;
    applyStimulus(r6, a6, d6, 1'b0, 1'b0);
    drain();

    $display("[TB] timeout with stuck master");
    stuck = 1'b1;
    applyStimulus(1'b1, 7'($urandom), 8'($urandom), 1'b1, 1'b0);
    n = 0;
    while (!m_start_txn && n < 10) begin tick(); n++; end
    t0 = cyc;
    n  = 0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    checkOutput("timeout_delay", 32'(cyc - t0), 32'(TOUT));
    checkOutput("timeout_flag", 32'(rsp_timeout), 32'(1));
    applyStimulus(1'b0, 7'h2A, 8'h3E, 1'b0, 1'b0);
    repeat (8) tick();
    checkOutput("stuck_no_issue", 32'(m_start_txn), 32'(0));
    checkOutput("stuck_level", 32'(fifo_level), 32'(1));
    checkOutput("stuck_not_idle", 32'(idle), 32'(0));
    release_bus = 1'b1;
    n = 0;
    while (m_busy && n < 20) begin tick(); n++; end
    checkOutput("stuck_released", 32'(m_busy), 32'(0));
    stuck       = 1'b0;
    release_bus = 1'b0;
    drain();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) begin
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
      end
      applyStimulus(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, 1'b1);
    end
    drain();

    $display("[TB] reset mid-read");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 7'($urandom), 8'($urandom), 1'b0, 1'b0);
    n = 0;
    while (!m_busy && n < 20) begin tick(); n++; end
    checkOutput("midread_queued", 32'(fifo_level), 32'(2));
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("mid_rst_start", 32'(m_start_txn), 32'(0));
    checkOutput("mid_rst_level", 32'(fifo_level), 32'(0));
    checkOutput("mid_rst_idle", 32'(idle), 32'(1));
    exp_q.delete();
    iss_q.delete();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 7'h50, 8'h00, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Command front-end for the single-byte I2C master. It buffers read/write commands in a small FIFO and issues them one at a time over the master's start_txn/busy/done handshake. It holds the master's rw/sub_addr/data_in stable for the whole transaction and returns one response per command: read data, NACK flag and timeout flag. It sits directly upstream of the master, in the clk_400 domain.

## Interface
- DEPTH, 4: command FIFO entries, power of two, at least 2.
- TIMEOUT_CYCLES, 256: clk_400 cycles allowed from start_txn assertion to done.
- clk_400  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_addr  in  7  target address.
- cmd_wdata  in  8  write byte; ignored for reads.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  8  read byte; 0 for writes, NACK or timeout.
- rsp_nack  out  1  master reported ack_error.
- rsp_timeout  out  1  done not seen within TIMEOUT_CYCLES.
- m_start_txn  out  1  to master start_txn.
- m_rw  out  1  to master rw.
- m_sub_addr  out  7  to master sub_addr.
- m_data_in  out  8  to master data_in.
- m_data_out  in  8  from master data_out.
- m_busy  in  1  from master busy.
- m_done  in  1  from master done.
- m_ack_error  in  1  from master ack_error.
- fifo_level  out  $clog2(DEPTH)+1  FIFO entries.
- idle  out  1  FSM in S_IDLE and FIFO empty.

## Operation
- **FIFO**
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = (fifo_level != DEPTH), with no bypass when full.
  - Pop only from S_IDLE.
  - Same-cycle push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- **S_IDLE**
  - Condition: FIFO non-empty and rsp_valid == 0.
  - Action: pop the head into m_rw/m_sub_addr/m_data_in, set m_start_txn = 1, clear the timer, go to S_ISSUE.
- **S_ISSUE**
  - Hold m_start_txn until m_busy == 1.
  - Then clear m_start_txn and go to S_WAIT.
- **S_WAIT**
  - On m_done == 1:
    - rsp_nack = m_ack_error.
    - rsp_rdata = (m_rw && !m_ack_error) ? m_data_out : 0.
    - rsp_timeout = 0.
    - rsp_valid = 1.
    - Go to S_GAP.
- **Timeout**
  - The timer counts every cycle in S_ISSUE and S_WAIT.
  - At count TIMEOUT_CYCLES-1 with no m_done:
    - Clear m_start_txn.
    - rsp_timeout = 1, rsp_nack = 0, rsp_rdata = 0, rsp_valid = 1.
    - Go to S_GAP.
  - m_done in that same cycle wins over timeout.
- **S_GAP**
  - Wait for a cycle with m_busy == 0 && m_done == 0, then go to S_IDLE.
  - This guarantees the master has returned to IDLE before the next start.
  - A stuck master therefore blocks further issue.
- **Response output**
  - rsp_valid clears on rsp_valid && rsp_ready.
  - Response fields stay stable while rsp_valid is high.
- **Stability**
  - m_rw/m_sub_addr/m_data_in change only on a pop.
- **Responses**
  - Exactly one response per accepted command, in order.
- **Reset**
  - Applies at any time, including mid-transaction.
  - Empties the FIFO and sets the FSM to S_IDLE.
  - Does not wait on the master.

## Timing
- **Reset values**
  - 0: cmd_ready-relevant level (fifo_level), rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, m_start_txn, m_rw, m_sub_addr, m_data_in.
  - 1: cmd_ready, idle.
- **Registered outputs**: all outputs except cmd_ready and idle.
- **Issue latency**: command pushed at edge N → m_start_txn high after edge N+1 (FIFO empty, no response pending).
- **Busy latency**: the master shows busy 2 cycles after m_start_txn is seen; m_start_txn drops the edge after m_busy is sampled high.
- **Response latency**: rsp_valid rises the edge after m_done is sampled high.
- **Earliest next start**: 2 cycles after done with an idle master.

## Structure
- Package i2c_pkg:
  - i2c_cmd_t struct {rw, addr[6:0], wdata[7:0]}.
  - i2c_rsp_t struct {rdata, nack, timeout}.
  - seq_state_t enum {S_IDLE, S_ISSUE, S_WAIT, S_GAP}.
- Sub-module i2c_cmd_fifo:
  - Synchronous FIFO of i2c_cmd_t, parameter DEPTH.
  - Ports: push/pop/full/empty/level.
- The FSM and timer live in the top module.

## Test plan
- Write 0x2A/0xA5, bench target ACKs both bytes → master sees rw=0, sub_addr=0x2A, data_in=0xA5 held to done; response rdata=0x00, nack=0, timeout=0.
- Read 0x50, target returns 0x3C → response rdata=0x3C, nack=0.
- Address 0x11 NACKed → response nack=1, rdata=0x00; next command starts only after master busy=0, done=0.
- DEPTH=4, rsp_ready=0, push 6 commands back to back:
  - Command 1 is issued and its response is held.
  - Commands 2–5 fill the FIFO (level=4); cmd_ready=0 refuses command 6.
  - Raising rsp_ready yields in-order responses; command 6 is then accepted.
- TIMEOUT_CYCLES=16, master model holds busy=1 and never asserts done → rsp_timeout=1 exactly 16 cycles after m_start_txn rose; no further issue until busy drops.
- rst_n low mid-read, with 2 commands queued → next cycle rsp_valid=0, m_start_txn=0, fifo_level=0, idle=1; a post-reset command completes normally.
